// File: rtl/c7bifu_pkg.sv
// c7bifu_pkg: shared fetch constants, entry width and fetch FSM encoding
package c7bifu_pkg;
  localparam int FETCH_ALIGN = 3;
  localparam int ENTRY_W = 96;
  localparam logic [31:0] DEF_RESET_PC = 32'h1c000000;
  typedef enum logic {RUN = 1'b0, REQ = 1'b1} fetch_state_t;
endpackage

// File: rtl/c7bifu_fetch_buf.sv
// c7bifu_fetch_buf: in-order response FIFO of {addr, data} entries
module c7bifu_fetch_buf import c7bifu_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic [CNT_W-1:0]   cnt,
  output logic               empty
);
  localparam int IW = $clog2(DEPTH);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr, rd_ptr;
  logic full;
  assign cnt = wr_ptr - rd_ptr;
  assign empty = cnt == '0;
  assign full = cnt == CNT_W'(DEPTH);
  assign rdata = mem[rd_ptr[IW-1:0]];
  // pointers carry one extra wrap bit so their difference is the occupancy
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + CNT_W'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + CNT_W'(1);
    end
  // entry storage, written at the tail
  always_ff @(posedge clk)
    if (push && !full && !clear) mem[wr_ptr[IW-1:0]] <= wdata;
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn) !(push && full))
    else $error("fetch buffer overflow");
endmodule

// File: rtl/c7bifu_fetch.sv
// c7bifu_fetch: credit-limited sequential fetch front end feeding the IQ
module c7bifu_fetch import c7bifu_pkg::*; #(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          BUF_DEPTH = 4,
  parameter int          CNT_W     = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  input  logic        iq_full,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] data_addr,
  output logic [63:0] data,
  output logic        data_vld
);
  localparam logic [31:0] STEP = 32'd1 << FETCH_ALIGN;
  localparam logic [31:0] MASK = ~(STEP - 32'd1);
  fetch_state_t state, state_nxt;
  logic [31:0] pc, resp_addr;
  logic [CNT_W-1:0] outst, outst_nxt, drop_cnt, buf_cnt;
  logic [ENTRY_W-1:0] head;
  logic buf_empty, credit, issue, ack, push;
  assign mem_req = state == REQ;
  assign ack = mem_req && mem_ack;
  assign credit = {1'b0, outst} + {1'b0, buf_cnt} < (CNT_W+1)'(BUF_DEPTH);
  assign issue = state == RUN && state_nxt == REQ;
  assign outst_nxt = outst + CNT_W'(ack) - CNT_W'(mem_rvalid);
  assign push = mem_rvalid && !flush && drop_cnt == '0;
  assign data_vld = !buf_empty && !iq_full && !flush;
  assign data = data_vld ? head[63:0] : '0;
  assign data_addr = data_vld ? head[95:64] : '0;
  // issue from RUN when a buffer slot is guaranteed; hold REQ until acked
  always_comb
    state_nxt = state == RUN ? (!flush && credit ? REQ : RUN) : (mem_ack ? RUN : REQ);
  // fetch state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= RUN;
    else state <= state_nxt;
  // pc advances at issue so a flush during a pending request needs no fixup
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      pc <= RESET_PC & MASK;
      resp_addr <= RESET_PC & MASK;
      outst <= '0;
      drop_cnt <= '0;
      mem_addr <= '0;
    end else begin
      outst <= outst_nxt;
      if (issue) mem_addr <= pc;
      if (flush) begin
        pc <= flush_addr & MASK;
        resp_addr <= flush_addr & MASK;
        drop_cnt <= outst_nxt + CNT_W'(mem_req && !mem_ack);
      end else begin
        if (issue) pc <= pc + STEP;
        if (push) resp_addr <= resp_addr + STEP;
        if (mem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
      end
    end
  c7bifu_fetch_buf #(.DEPTH(BUF_DEPTH), .CNT_W(CNT_W)) u_buf (
    .clk(clk),
    .resetn(resetn),
    .clear(flush),
    .push(push),
    .pop(data_vld),
    .wdata({resp_addr, mem_rdata}),
    .rdata(head),
    .cnt(buf_cnt),
    .empty(buf_empty)
  );
endmodule

// File: tb/tb_c7bifu_fetch.sv
// tb_c7bifu_fetch: randomized scoreboard bench with a stream-level fetch model
module tb_c7bifu_fetch;
  logic clk = 0, resetn = 0, flush = 0, iq_full = 0, mem_ack = 0, mem_rvalid = 0;
  logic [31:0] flush_addr = 0;
  logic [63:0] mem_rdata = 0;
  logic mem_req, data_vld;
  logic [31:0] mem_addr, data_addr;
  logic [63:0] data;

  c7bifu_fetch dut (
    .clk(clk), .resetn(resetn), .flush(flush), .flush_addr(flush_addr),
    .iq_full(iq_full), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .data_addr(data_addr),
    .data(data), .data_vld(data_vld)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int epoch; int due; } rsp_t;
  rsp_t rq[$];
  logic [31:0] sb[$];
  int n_chk = 0, n_err = 0, cyc = 0, epoch = 0;
  int lat = 2, ack_pct = 100, ack_wait = 0, rv_pct = 100, fmode = 0;
  bit full_knob = 0, flush_pend = 0, req_seen = 0, rv_ok;
  logic [31:0] flush_tgt = 0, exp_pc = 32'h1c000000, req_addr = 0;
  int req_epoch = 0, req_age = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // memory model + stream-level reference: drive after posedge, judge at negedge
  initial forever begin
    rsp_t e;
    logic [31:0] a;
    @(posedge clk);
    #1;
    cyc++;
    if (!resetn) begin
      flush = 0; mem_ack = 0; mem_rvalid = 0; mem_rdata = 0; iq_full = 0;
    end else begin
      rv_ok = rq.size() > 0 && rq[0].due <= cyc;
      iq_full = full_knob;
      flush = 0;
      mem_ack = mem_req && (req_seen ? req_age : 0) >= ack_wait && $urandom_range(0, 99) < ack_pct;
      mem_rvalid = rv_ok && $urandom_range(0, 99) < rv_pct;
      if (flush_pend && (fmode == 0 || (fmode == 1 && mem_req && !mem_ack) ||
                         (fmode == 2 && mem_req && rv_ok))) begin
        flush = 1; flush_addr = flush_tgt; flush_pend = 0;
        if (fmode == 2) begin mem_ack = 1; mem_rvalid = 1; end
      end
      mem_rdata = mem_rvalid ? {rq[0].addr + 32'd4, rq[0].addr} : 64'h0;
    end
    @(negedge clk);
    if (!resetn) begin
      rq.delete(); sb.delete(); req_seen = 0; exp_pc = 32'h1c000000;
    end else begin
      chk("data_vld", data_vld, sb.size() > 0 && !iq_full && !flush);
      if (data_vld && sb.size() > 0) begin
        a = sb.pop_front();
        chk("data_addr", data_addr, a);
        chk("data", data, {a + 32'd4, a});
      end else if (!data_vld) chk("idle_zero", {data_addr, data}, 96'h0);
      if (mem_req) begin
        if (!req_seen) begin
          chk("mem_addr", mem_addr, exp_pc);
          exp_pc = exp_pc + 32'd8;
          req_seen = 1; req_addr = mem_addr; req_epoch = epoch; req_age = 0;
        end else chk("mem_addr_hold", mem_addr, req_addr);
        req_age++;
        if (mem_ack) begin
          rq.push_back('{req_addr, req_epoch, cyc + lat});
          req_seen = 0;
        end
      end
      if (mem_rvalid) begin
        e = rq.pop_front();
        if (!flush && e.epoch == epoch) sb.push_back(e.addr);
      end
      if (flush) begin
        epoch++;
        sb.delete();
        exp_pc = flush_addr & ~32'h7;
      end
      chk("credit", rq.size() + sb.size() <= 4, 1);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin @(negedge clk); #2; end
  endtask

  task automatic do_flush(input int mode, input logic [31:0] tgt);
    fmode = mode; flush_tgt = tgt; flush_pend = 1;
    for (int i = 0; i < 200 && flush_pend; i++) cycles(1);
    chk("flush_issued", flush_pend, 0);
    flush_pend = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_data_vld", data_vld, 0);
    chk("rst_data", data, 0);
    chk("rst_data_addr", data_addr, 0);
    @(negedge clk); #2 resetn = 1;
    // steady stream
    cycles(40);
    // back-pressure: buffer fills to the credit limit, then drains without gaps
    full_knob = 1;
    cycles(14);
    chk("hold_buf", sb.size(), 4);
    chk("hold_outst", rq.size(), 0);
    full_knob = 0;
    for (int i = 0; i < 4; i++) begin cycles(1); chk("drain_vld", data_vld, 1); end
    // flush with two in flight
    lat = 5;
    cycles(10);
    do_flush(0, 32'h1c000104);
    cycles(30);
    // flush while a request is pending
    lat = 2; ack_wait = 3;
    cycles(6);
    do_flush(1, 32'h1c000200);
    cycles(30);
    ack_wait = 0;
    // flush coinciding with ack and rvalid
    for (int i = 0; i < 5; i++) begin
      do_flush(2, $urandom());
      cycles(8);
    end
    // randomized mix, including a wrap near the top of the address space
    for (int r = 0; r < 30; r++) begin
      lat = $urandom_range(1, 4); ack_pct = $urandom_range(40, 100);
      rv_pct = $urandom_range(40, 100); full_knob = $urandom_range(0, 3) == 0;
      if (r == 5) begin fmode = 0; flush_tgt = 32'hfffffff3; flush_pend = 1; end
      else if ($urandom_range(0, 2) == 0) begin
        fmode = $urandom_range(0, 2); flush_tgt = $urandom(); flush_pend = 1;
      end
      cycles(12);
    end
    flush_pend = 0; full_knob = 0; ack_pct = 100; rv_pct = 100; lat = 2;
    cycles(20);
    // asynchronous reset with data buffered
    full_knob = 1;
    cycles(6);
    resetn = 0;
    #1;
    chk("async_mem_req", mem_req, 0);
    chk("async_data_vld", data_vld, 0);
    full_knob = 0;
    cycles(2);
    resetn = 1;
    cycles(30);
    // stop acking and let everything in flight drain
    ack_pct = 0;
    for (int i = 0; i < 200 && (rq.size() > 0 || sb.size() > 0); i++) cycles(1);
    chk("final_outst", rq.size(), 0);
    chk("final_buf", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
